// File: rtl/set24_time_setter.sv
// set24_time_setter: button-driven 24-hour set-mode front end producing the
// set state, working hours/minutes, blink phase and the commit pulse.
module set24_time_setter #(
    parameter int QUARTER_TICKS = 250,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnMode,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic [4:0] curHours,
    input  logic [5:0] curMinutes,
    output logic [1:0] currentState,
    output logic       real_quarter,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic       commit
);
    typedef enum logic [1:0] {IDLE = 2'd0, SET_H = 2'd1, SET_M = 2'd2} state_t;

    localparam int QW = $clog2(QUARTER_TICKS + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(QUARTER_TICKS - 1);
    localparam logic [RW-1:0] R_FIRE   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    state_t        state, state_n;
    logic [4:0]    hours_n;
    logic [5:0]    minutes_n;
    logic          rq_n, commit_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [RW-1:0] rcnt, rcnt_raw, rcnt_n;
    logic [2:0]    hist;
    logic          mode_p, up_p, down_p, in_set, step_raw, act, restart;

    assign mode_p = btnMode & ~hist[2];
    assign up_p   = btnUp & ~hist[1];
    assign down_p = btnDown & ~hist[0];
    assign in_set = (state == SET_H) || (state == SET_M);

    // rcnt counts cycles since the press step; 0 means no hold in progress
    always_comb begin
        step_raw = 1'b0;
        rcnt_raw = '0;
        if (btnUp && btnDown) begin
            rcnt_raw = '0;
        end else if (up_p || down_p) begin
            step_raw = 1'b1;
            rcnt_raw = RW'(1);
        end else if ((btnUp ^ btnDown) && rcnt != '0) begin
            step_raw = (rcnt == R_FIRE);
            rcnt_raw = (rcnt == R_FIRE) ? R_RELOAD : rcnt + 1'b1;
        end
    end

    assign act     = in_set && !mode_p && step_raw;
    assign restart = !in_set || mode_p || act;

    always_comb begin
        state_n = (state == IDLE || state == SET_H || state == SET_M) ? state : IDLE;
        if (mode_p)
            state_n = (state == IDLE) ? SET_H : (state == SET_H) ? SET_M : IDLE;
        commit_n  = mode_p && state == SET_M;
        rcnt_n    = (in_set && !mode_p) ? rcnt_raw : '0;
        hours_n   = hours;
        minutes_n = minutes;
        if (state == IDLE) begin
            hours_n   = (curHours > 5'd23) ? 5'd23 : curHours;
            minutes_n = (curMinutes > 6'd59) ? 6'd59 : curMinutes;
        end else if (act && state == SET_H) begin
            hours_n = btnUp ? ((hours == 5'd23) ? 5'd0 : hours + 5'd1)
                            : ((hours == 5'd0) ? 5'd23 : hours - 5'd1);
        end else if (act && state == SET_M) begin
            minutes_n = btnUp ? ((minutes == 6'd59) ? 6'd0 : minutes + 6'd1)
                              : ((minutes == 6'd0) ? 6'd59 : minutes - 6'd1);
        end
        qcnt_n = restart ? '0 : (qcnt == Q_LAST) ? '0 : qcnt + 1'b1;
        rq_n   = restart ? 1'b1 : (qcnt == Q_LAST) ? ~real_quarter : real_quarter;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hours        <= '0;
            minutes      <= '0;
            real_quarter <= 1'b1;
            commit       <= 1'b0;
            qcnt         <= '0;
            rcnt         <= '0;
            hist         <= 3'b111;
        end else begin
            state        <= state_n;
            hours        <= hours_n;
            minutes      <= minutes_n;
            real_quarter <= rq_n;
            commit       <= commit_n;
            qcnt         <= qcnt_n;
            rcnt         <= rcnt_n;
            hist         <= {btnMode, btnUp, btnDown};
        end
    end

    assign currentState = state;
endmodule

// File: tb/tb_set24_time_setter.sv
// tb_set24_time_setter: directed and random button stimulus checked every
// cycle against a cycle-counting reference model of the set-mode rules.
module tb_set24_time_setter;
    localparam int QT = 4, RD = 8, RP = 3;

    logic       clk = 1'b0, reset = 1'b1, btnMode = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
    logic [4:0] curHours = '0;
    logic [5:0] curMinutes = '0;
    logic [1:0] currentState;
    logic       real_quarter, commit;
    logic [4:0] hours;
    logic [5:0] minutes;

    int checks = 0, errors = 0;
    int ms, mh, mm, mc, mt, mheld;
    bit pm, pu, pd;

    set24_time_setter #(.QUARTER_TICKS(QT), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown),
        .curHours(curHours), .curMinutes(curMinutes), .currentState(currentState),
        .real_quarter(real_quarter), .hours(hours), .minutes(minutes), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Hold time is cycles since the press; blink phase is derived from
    // cycles since the last restart.
    task automatic model_step();
        bit mp, up, dp, step;
        step = 1'b0;
        if (reset) begin
            ms = 0; mh = 0; mm = 0; mc = 0; mt = 0; mheld = -1; pm = 1; pu = 1; pd = 1;
            return;
        end
        mp = btnMode && !pm;
        up = btnUp && !pu;
        dp = btnDown && !pd;
        pm = btnMode; pu = btnUp; pd = btnDown;
        mc = 0;
        if (ms == 0) begin
            mh = (curHours > 23) ? 23 : int'(curHours);
            mm = (curMinutes > 59) ? 59 : int'(curMinutes);
        end
        if (ms != 0 && !mp) begin
            if (btnUp && btnDown) mheld = -1;
            else if (up || dp) begin step = 1; mheld = 0; end
            else if ((btnUp || btnDown) && mheld >= 0) begin
                mheld++;
                step = (mheld >= RD) && ((mheld - RD) % RP == 0);
            end else mheld = -1;
        end else mheld = -1;
        if (step) begin
            if (ms == 1) mh = (mh + (btnUp ? 1 : 23)) % 24;
            else mm = (mm + (btnUp ? 1 : 59)) % 60;
        end
        if (mp) begin
            mc = (ms == 2);
            ms = (ms + 1) % 3;
        end
        mt = (mp || step || ms == 0) ? 0 : mt + 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("state", currentState, ms);
        chk("hours", hours, mh);
        chk("minutes", minutes, mm);
        chk("real_quarter", real_quarter, (ms == 0) ? 1 : ((mt / QT) % 2 == 0));
        chk("commit", commit, mc);
    endtask

    initial begin
        int pat [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        @(negedge clk);
        tick(); tick();
        chk("rst_state", currentState, 0); chk("rst_h", hours, 0);
        chk("rst_rq", real_quarter, 1); chk("rst_commit", commit, 0);
        reset = 0; curHours = 13; curMinutes = 45; tick();
        chk("idle_h", hours, 13); chk("idle_m", minutes, 45);
        curHours = 30; tick();
        chk("clamp_h", hours, 23);
        curHours = 23; curMinutes = 59; tick();
        btnMode = 1; tick(); chk("seth_state", currentState, 1); chk("seth_h", hours, 23);
        btnMode = 0; tick();
        btnUp = 1; tick(); chk("wrap_h", hours, 0); btnUp = 0; tick();
        btnMode = 1; tick(); chk("setm_state", currentState, 2); btnMode = 0; tick();
        btnUp = 1; tick(); chk("wrap_m", minutes, 0); btnUp = 0; tick();
        btnMode = 1; tick();
        chk("commit_pulse", commit, 1); chk("commit_h", hours, 0);
        chk("commit_m", minutes, 0); chk("commit_state", currentState, 0);
        btnMode = 0; tick(); chk("commit_end", commit, 0);
        curHours = 0; curMinutes = 0; tick();
        btnMode = 1; tick(); btnMode = 0; tick();
        btnDown = 1; tick(); chk("down_h", hours, 23); btnDown = 0; tick();
        btnMode = 1; tick(); btnMode = 0; tick();
        btnDown = 1; tick(); chk("down_m", minutes, 59); btnDown = 0; tick();
        btnMode = 1; tick(); btnMode = 0; tick();
        btnMode = 1; tick(); chk("blink_0", real_quarter, pat[0]); btnMode = 0;
        for (int i = 1; i < 9; i++) begin
            tick();
            chk($sformatf("blink_%0d", i), real_quarter, pat[i]);
        end
        repeat (4) tick();
        chk("blink_low", real_quarter, 0);
        tick();
        btnUp = 1; tick(); chk("blink_restart", real_quarter, 1); btnUp = 0;
        tick(); chk("blink_hold", real_quarter, 1);
        repeat (3) tick(); chk("blink_rewrap", real_quarter, 0);
        curHours = 5; curMinutes = 10;
        btnMode = 1; tick(); btnMode = 0; tick();
        btnMode = 1; tick(); btnMode = 0; tick();
        btnMode = 1; tick(); chk("h5", hours, 5); btnMode = 0; tick();
        btnMode = 1; btnUp = 1; tick();
        chk("mu_state", currentState, 2); chk("mu_h", hours, 5); chk("mu_m", minutes, 10);
        btnMode = 0; btnUp = 0; tick();
        btnUp = 1; repeat (20) tick(); btnUp = 0; tick();
        chk("repeat_m", minutes, 15);
        btnUp = 1; btnDown = 1; repeat (12) tick(); btnUp = 0; btnDown = 0; tick();
        chk("both_m", minutes, 15);
        reset = 1; btnMode = 1; tick();
        chk("rmid_state", currentState, 0); chk("rmid_h", hours, 0);
        chk("rmid_m", minutes, 0); chk("rmid_commit", commit, 0);
        reset = 0; repeat (3) tick(); chk("held_mode", currentState, 0);
        btnMode = 0; tick(); btnMode = 1; tick(); chk("repress", currentState, 1);
        btnMode = 0; tick();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) btnUp = ~btnUp;
            if ($urandom_range(0, 15) == 0) btnDown = ~btnDown;
            btnMode = ($urandom_range(0, 39) == 0) ? ~btnMode : btnMode;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 9) == 0) begin
                curHours = 5'($urandom_range(0, 31));
                curMinutes = 6'($urandom_range(0, 63));
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/set24_time_setter.md
Name: set24_time_setter

Overview:
- Sequential front end of the 24-hour set mode: turns Mode/Up/Down button levels into the set-state code, the working hours/minutes values and the blink phase.
- Its outputs `currentState`, `real_quarter`, `hours` and `minutes` feed the 24-hour set display decoder directly.
- On leaving set mode it emits a one-cycle commit pulse so the timekeeping core can load the new time.
- In idle it tracks the running time, so set mode always starts from the current time.

Parameters:
- QUARTER_TICKS, 250: clock cycles per blink half-phase; `real_quarter` toggles once per QUARTER_TICKS cycles.
- REPEAT_DELAY, 500: cycles Up/Down must be held after its press step before auto-repeat starts.
- REPEAT_PERIOD, 100: cycles between auto-repeat steps while held.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btnMode  in  1  Mode button level, already synchronized/debounced, active high.
- btnUp  in  1  Up button level, already synchronized/debounced, active high.
- btnDown  in  1  Down button level, already synchronized/debounced, active high.
- curHours  in  5  running hours from the timekeeping core, 0..23.
- curMinutes  in  6  running minutes from the timekeeping core, 0..59.
- currentState  out  2  0 = IDLE, 1 = SET_H, 2 = SET_M.
- real_quarter  out  1  blink phase; 1 = digits visible.
- hours  out  5  working hours value, always 0..23.
- minutes  out  6  working minutes value, always 0..59.
- commit  out  1  one-cycle pulse carrying the final hours/minutes.

Behaviour:
- All outputs are registered.
- Reset values: `currentState`=0, `hours`=0, `minutes`=0, `real_quarter`=1, `commit`=0; quarter counter and repeat counters = 0; button history registers = 1, so a button held through reset must be released before it counts.
- Edge detect: a press is a button sampled 1 while its history register is 0. The action it causes is visible after that same clock edge (1-cycle latency from the sampled level).
- State machine, Mode press:
  - IDLE -> SET_H.
  - SET_H -> SET_M.
  - SET_M -> IDLE, with `commit`=1 for exactly that cycle; `hours`/`minutes` hold the final set values during the pulse.
  - Encoding 3 is illegal and returns to IDLE next cycle with no commit.
- IDLE:
  - `hours`/`minutes` load `curHours`/`curMinutes` every cycle, clamped (hours > 23 -> 23, minutes > 59 -> 59).
  - Up/Down are ignored.
  - `real_quarter` is forced to 1.
- SET_H / SET_M:
  - Registers no longer track the running time.
  - Up press increments the selected field: hours wrap 23 -> 0, minutes wrap 59 -> 0. The other field is unchanged.
  - Down press decrements: hours wrap 0 -> 23, minutes wrap 0 -> 59.
  - Steps use modular arithmetic within field width; no overflow states are possible.
- Auto-repeat:
  - While exactly one of Up/Down stays high in a set state, a hold counter starts at its press.
  - A first repeat step fires REPEAT_DELAY cycles after the press step, then one step every REPEAT_PERIOD cycles.
  - Release, the other button asserting, a Mode press or reset clears the counter.
- Simultaneous events:
  - Up and Down both high: no step, and repeat counters clear.
  - A Mode press in the same cycle as an Up/Down press or repeat: Mode wins, the step is dropped, and the new state starts with repeat counters cleared.
- Blink:
  - In set states a counter runs 0..QUARTER_TICKS-1; at its wrap `real_quarter` toggles.
  - Entering SET_H or SET_M, and any Up/Down step, resets the counter to 0 and sets `real_quarter`=1, so the value is visible right after a change.
- Reset mid-operation, in any state or mid-hold: all registers go to reset values next edge; no commit is emitted.

Test Plan:
- Reset, then IDLE with curHours=13, curMinutes=45 -> hours=13, minutes=45, currentState=0, real_quarter=1; curHours=30 -> hours=23.
- Mode press from IDLE with time 23:59; Up press; Mode; Up press; Mode -> SET_H shows hours=0 (wrap); SET_M shows minutes=0; on return to IDLE, commit high exactly 1 cycle with hours=0, minutes=0.
- In SET_M with minutes=0, Down press -> minutes=59; in SET_H with hours=0, Down press -> hours=23.
- QUARTER_TICKS=4, in SET_H with no buttons -> real_quarter pattern 1,1,1,1,0,0,0,0,1...; an Up step mid-low-phase -> real_quarter=1 the next cycle and the counter restarts.
- REPEAT_DELAY=8, REPEAT_PERIOD=3, Up held 20 cycles in SET_M from minutes=10 -> steps at press, +8, +11, +14, +17 -> minutes=15; Up+Down held together -> no change.
- Mode and Up pressed in the same cycle in SET_H at hours=5 -> state becomes SET_M, hours stays 5.
- reset asserted mid-SET_M -> next cycle currentState=0, hours=0, minutes=0, commit=0.
- btnMode held through reset release -> no transition until it is released and pressed again.
